// File: rtl/gray_window_buffer.sv
// gray_window_buffer
// Collects a 4x4 window of grayscale pixels, one per save pulse from the
// main control unit, and presents the full window to the gradient stage.
// The control state, flags and count are registered, so they follow a
// save by one clock edge. The window bus reads zero whenever the buffer
// is empty.
module gray_window_buffer #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [PIX_W-1:0]       i_gray_data,
  input  logic                   i_grayscale_data_ready,
  input  logic                   i_b1_save,
  input  logic                   i_b1_clear,
  output logic                   o_b1_full,
  output logic                   o_b1_empty,
  output logic [4:0]             o_count,
  output logic [DEPTH*PIX_W-1:0] o_window,
  output logic                   o_window_valid,
  output logic                   o_overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] LAST_IDX = 5'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [4:0]        r_count;
  logic [4:0]        w_count_next;
  logic              r_full;
  logic              r_empty;
  logic              r_window_valid;
  logic              r_overflow;
  logic              w_accept;
  logic              w_overflow_set;
  logic [PIX_W-1:0]  r_mem [DEPTH];
  logic [DEPTH*PIX_W-1:0] w_window;

  // State register: returns to EMPTY immediately on reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: clear wins over everything, the last slot moves to FULL.
  always_comb begin
    w_next_state = r_state;
    if (i_b1_clear) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_next_state = (r_count == LAST_IDX) ? ST_FULL : ST_FILLING;
          end else begin
            w_next_state = ST_EMPTY;
          end
        end
        ST_FILLING: begin
          if (w_accept && (r_count == LAST_IDX)) begin
            w_next_state = ST_FULL;
          end else begin
            w_next_state = ST_FILLING;
          end
        end
        ST_FULL:  w_next_state = ST_FULL;
        default:  w_next_state = ST_EMPTY;
      endcase
    end
  end

  // Control decode: which save pulses are accepted and which are errors.
  always_comb begin
    w_accept       = 1'b0;
    w_overflow_set = 1'b0;
    if (i_b1_save && !i_b1_clear) begin
      if (i_grayscale_data_ready && (r_state != ST_FULL)) begin
        w_accept = 1'b1;
      end else begin
        w_overflow_set = 1'b1;
      end
    end else begin
      w_accept       = 1'b0;
      w_overflow_set = 1'b0;
    end
  end

  // Next count: clear zeroes it, an accepted save bumps it (never past DEPTH).
  always_comb begin
    w_count_next = r_count;
    if (i_b1_clear) begin
      w_count_next = 5'd0;
    end else if (w_accept) begin
      w_count_next = r_count + 5'd1;
    end else begin
      w_count_next = r_count;
    end
  end

  // Registered status outputs, computed from the next state so they line up
  // with the state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count        <= 5'd0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_window_valid <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_count        <= w_count_next;
      r_full         <= (w_next_state == ST_FULL);
      r_empty        <= (w_next_state == ST_EMPTY);
      r_window_valid <= (w_next_state == ST_FULL) && (r_state != ST_FULL);
      r_overflow     <= r_overflow | w_overflow_set;
    end
  end

  // Pixel storage: the accepted pixel lands in the slot named by the count.
  // Storage is not cleared; the empty flag masks stale contents instead.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_count[AW-1:0]] <= i_gray_data;
    end
  end

  // Window packing: slot k at bits [k*PIX_W +: PIX_W], zero while empty.
  always_comb begin
    w_window = '0;
    if (!r_empty) begin
      for (int k = 0; k < DEPTH; k++) begin
        w_window[k*PIX_W +: PIX_W] = r_mem[k];
      end
    end else begin
      w_window = '0;
    end
  end

  assign o_b1_full      = r_full;
  assign o_b1_empty     = r_empty;
  assign o_count        = r_count;
  assign o_window       = w_window;
  assign o_window_valid = r_window_valid;
  assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_gray_window_buffer.sv
// Directed bench for gray_window_buffer. Inputs change on falling edges,
// outputs are sampled on falling edges (or between edges for async reset).
module tb_gray_window_buffer;

  logic         clk;
  logic         n_rst;
  logic [7:0]   i_gray_data;
  logic         i_grayscale_data_ready;
  logic         i_b1_save;
  logic         i_b1_clear;
  logic         o_b1_full;
  logic         o_b1_empty;
  logic [4:0]   o_count;
  logic [127:0] o_window;
  logic         o_window_valid;
  logic         o_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_win;

  gray_window_buffer #(.PIX_W(8), .DEPTH(16)) dut (
    .clk                    (clk),
    .n_rst                  (n_rst),
    .i_gray_data            (i_gray_data),
    .i_grayscale_data_ready (i_grayscale_data_ready),
    .i_b1_save              (i_b1_save),
    .i_b1_clear             (i_b1_clear),
    .o_b1_full              (o_b1_full),
    .o_b1_empty             (o_b1_empty),
    .o_count                (o_count),
    .o_window               (o_window),
    .o_window_valid         (o_window_valid),
    .o_overflow             (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    n_rst = 1'b0;
    i_b1_save = 1'b0;
    i_b1_clear = 1'b0;
    i_grayscale_data_ready = 1'b1;
    i_gray_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // One save pulse; returns at the falling edge after the sampling edge.
  task automatic pulse_save(input logic [7:0] d, input logic rdy);
    @(negedge clk);
    i_gray_data = d;
    i_grayscale_data_ready = rdy;
    i_b1_save = 1'b1;
    @(negedge clk);
    i_b1_save = 1'b0;
    i_grayscale_data_ready = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (o_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", o_count); end
    n_checks++; if (o_b1_empty !== 1'b1 || o_b1_full !== 1'b0) begin n_fail++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", o_b1_empty, o_b1_full); end
    n_checks++; if (o_window !== 128'd0 || o_window_valid !== 1'b0 || o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_outs got win=%h wv=%b ov=%b exp 0", o_window, o_window_valid, o_overflow); end
  endtask

  task automatic test_fill();
    logic [7:0] d;
    exp_win = 128'd0;
    for (int i = 0; i < 16; i++) begin
      d = 8'h10 + 8'(i);
      exp_win[i*8 +: 8] = d;
      pulse_save(d, 1'b1);
      n_checks++; if (o_count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, o_count, i + 1); end
      n_checks++; if (o_b1_full !== (i == 15) || o_window_valid !== (i == 15)) begin n_fail++; $display("FAIL fill_full[%0d] got full=%b wv=%b exp %b", i, o_b1_full, o_window_valid, (i == 15)); end
      n_checks++; if (o_b1_empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty[%0d] got %b exp 0", i, o_b1_empty); end
    end
    n_checks++; if (o_window[7:0] !== 8'h10 || o_window[127:120] !== 8'h1F) begin n_fail++; $display("FAIL fill_ends got %h/%h exp 10/1f", o_window[7:0], o_window[127:120]); end
    n_checks++; if (o_window !== exp_win) begin n_fail++; $display("FAIL fill_window got %h exp %h", o_window, exp_win); end
    @(negedge clk);
    n_checks++; if (o_window_valid !== 1'b0 || o_b1_full !== 1'b1) begin n_fail++; $display("FAIL valid_once got wv=%b full=%b exp 0/1", o_window_valid, o_b1_full); end
  endtask

  task automatic test_overflow_and_clear();
    pulse_save(8'hEE, 1'b1);
    n_checks++; if (o_count !== 5'd16 || o_window !== exp_win) begin n_fail++; $display("FAIL ovf_hold got cnt=%0d win=%h exp 16 %h", o_count, o_window, exp_win); end
    n_checks++; if (o_overflow !== 1'b1 || o_window_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_flag got ov=%b wv=%b exp 1/0", o_overflow, o_window_valid); end
    @(negedge clk);
    i_b1_clear = 1'b1;
    @(negedge clk);
    i_b1_clear = 1'b0;
    n_checks++; if (o_count !== 5'd0 || o_b1_empty !== 1'b1 || o_b1_full !== 1'b0) begin n_fail++; $display("FAIL clear_state got cnt=%0d e=%b f=%b exp 0/1/0", o_count, o_b1_empty, o_b1_full); end
    n_checks++; if (o_window !== 128'd0) begin n_fail++; $display("FAIL clear_window got %h exp 0", o_window); end
    n_checks++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", o_overflow); end
    pulse_save(8'hAA, 1'b1);
    n_checks++; if (o_window[7:0] !== 8'hAA || o_count !== 5'd1) begin n_fail++; $display("FAIL save_after_clear got %h cnt=%0d exp aa 1", o_window[7:0], o_count); end
  endtask

  task automatic test_not_ready();
    apply_reset();
    pulse_save(8'h55, 1'b0);
    n_checks++; if (o_count !== 5'd0 || o_b1_empty !== 1'b1 || o_overflow !== 1'b1) begin n_fail++; $display("FAIL not_ready got cnt=%0d e=%b ov=%b exp 0/1/1", o_count, o_b1_empty, o_overflow); end
  endtask

  task automatic test_save_clear_same_cycle();
    apply_reset();
    for (int i = 0; i < 5; i++) pulse_save(8'(8'h30 + 8'(i)), 1'b1);
    n_checks++; if (o_count !== 5'd5) begin n_fail++; $display("FAIL five_saves got %0d exp 5", o_count); end
    @(negedge clk);
    i_gray_data = 8'h99;
    i_b1_save = 1'b1;
    i_b1_clear = 1'b1;
    @(negedge clk);
    i_b1_save = 1'b0;
    i_b1_clear = 1'b0;
    n_checks++; if (o_count !== 5'd0 || o_overflow !== 1'b0 || o_b1_empty !== 1'b1) begin n_fail++; $display("FAIL save_clear got cnt=%0d ov=%b e=%b exp 0/0/1", o_count, o_overflow, o_b1_empty); end
    n_checks++; if (o_window !== 128'd0) begin n_fail++; $display("FAIL save_clear_win got %h exp 0", o_window); end
  endtask

  task automatic test_async_reset_and_replay();
    logic [7:0] d;
    apply_reset();
    for (int i = 0; i < 7; i++) pulse_save(8'(8'h40 + 8'(i)), 1'b1);
    n_checks++; if (o_count !== 5'd7) begin n_fail++; $display("FAIL seven_saves got %0d exp 7", o_count); end
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    n_checks++; if (o_count !== 5'd0 || o_b1_empty !== 1'b1 || o_b1_full !== 1'b0 || o_window !== 128'd0) begin n_fail++; $display("FAIL async_reset got cnt=%0d e=%b f=%b win=%h exp 0/1/0/0", o_count, o_b1_empty, o_b1_full, o_window); end
    // Release and issue the first save in the same cycle: control-unit replay
    // (save, wait one cycle, sample full).
    for (int i = 0; i < 16; i++) begin
      d = 8'hC0 + 8'(i);
      @(negedge clk);
      n_rst = 1'b1;
      i_gray_data = d;
      i_b1_save = 1'b1;
      @(negedge clk);
      i_b1_save = 1'b0;
      @(negedge clk);
      n_checks++; if (o_b1_full !== (i == 15)) begin n_fail++; $display("FAIL replay_full[%0d] got %b exp %b", i, o_b1_full, (i == 15)); end
      if (i == 0) begin
        n_checks++; if (o_window[7:0] !== 8'hC0 || o_count !== 5'd1) begin n_fail++; $display("FAIL first_after_reset got %h cnt=%0d exp c0 1", o_window[7:0], o_count); end
      end
    end
    n_checks++; if (o_count !== 5'd16 || o_window[127:120] !== 8'hCF) begin n_fail++; $display("FAIL replay_end got cnt=%0d top=%h exp 16 cf", o_count, o_window[127:120]); end
  endtask

  initial begin
    n_rst = 1'b0;
    i_gray_data = 8'h00;
    i_grayscale_data_ready = 1'b0;
    i_b1_save = 1'b0;
    i_b1_clear = 1'b0;
    test_reset();
    test_fill();
    test_overflow_and_clear();
    test_not_ready();
    test_save_clear_same_cycle();
    test_async_reset_and_replay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_window_buffer.md
GRAY_WINDOW_BUFFER -- requirements
Module: gray_window_buffer

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning bits per grayscale pixel.
REQ-002 SHALL have parameter DEPTH, default 16, meaning pixels per 4x4 window; only 16 is required to work.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port n_rst, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port i_gray_data, input, PIX_W, meaning grayscale pixel from the grayscale stage, valid while i_grayscale_data_ready is high.
REQ-006 SHALL have port i_grayscale_data_ready, input, 1, meaning i_gray_data is valid; level signal.
REQ-007 SHALL have port i_b1_save, input, 1, meaning one-cycle registered pulse from the main control unit: write the current pixel.
REQ-008 SHALL have port i_b1_clear, input, 1, meaning one-cycle registered pulse from the main control unit: discard all stored pixels.
REQ-009 SHALL have port o_b1_full, output, 1, meaning DEPTH pixels are stored.
REQ-010 SHALL have port o_b1_empty, output, 1, meaning zero pixels are stored.
REQ-011 SHALL have port o_count, output, 5, meaning number of stored pixels, 0..16.
REQ-012 SHALL have port o_window, output, DEPTH*PIX_W, meaning window to the gradient stage; pixel k at bits [k*PIX_W +: PIX_W]; k = row*4 + col in write order.
REQ-013 SHALL have port o_window_valid, output, 1, meaning one-cycle pulse on the cycle o_b1_full first rises.
REQ-014 SHALL have port o_overflow, output, 1, meaning sticky error: a save was attempted while full or with data not ready.

Function
REQ-015 SHALL use one state machine with states EMPTY, FILLING and FULL, all registered.
- EMPTY -> FILLING on an accepted save.
- FILLING -> FULL when the 16th save is accepted.
- FILLING or FULL -> EMPTY on i_b1_clear.
REQ-016 SHALL accept a save when i_b1_save=1, i_grayscale_data_ready=1 and the state is not FULL.
- On an accepted save, write i_gray_data into slot o_count and increment o_count at the same rising edge.
REQ-017 SHALL, when i_b1_save=1 and the state is FULL, ignore the write, leave count and storage unchanged, and set o_overflow.
REQ-018 SHALL, when i_b1_save=1 and i_grayscale_data_ready=0, ignore the write and set o_overflow.
REQ-019 SHALL give latency of one clock edge:
- o_b1_full, o_b1_empty and o_count reflect an accepted save in the cycle after the pulse.
- The control unit samples full two cycles after it issues the save (B1_WAIT_2), so this latency is mandatory.
REQ-020 SHALL drive o_b1_full, o_b1_empty, o_count and o_window_valid from registers, not combinationally from inputs.
REQ-021 SHALL pulse o_window_valid high for exactly one cycle, the cycle after the accepted 16th save; it does not re-pulse while FULL.
REQ-022 SHALL, on i_b1_clear=1, set o_count=0 and o_b1_empty=1 at the next edge, and return the state to EMPTY.
- Pixel storage need not be zeroed, but o_window SHALL read all zeros while o_b1_empty=1.
REQ-023 SHALL give clear priority when i_b1_clear and i_b1_save are both high: the result is EMPTY, count 0, no write, and no overflow.
REQ-024 SHALL keep o_window constant while FULL until a clear occurs.
REQ-025 SHALL clear o_overflow only by reset; i_b1_clear does not clear it.
REQ-026 SHALL not wrap o_count: maximum 16, minimum 0.

Reset
REQ-027 SHALL, while n_rst=0, immediately and asynchronously force:
- state EMPTY, o_count=0, o_b1_empty=1;
- o_b1_full=0, o_window_valid=0, o_overflow=0, o_window=0.
REQ-028 SHALL, on reset asserted mid-fill, discard the partial window; after release the next accepted save lands in slot 0.
REQ-029 SHALL accept a save in the first cycle after reset release.

Verification
REQ-030 SHALL pass this scenario: 16 saves of data 0x10..0x1F with ready=1 -> o_count steps 1..16; o_b1_full=1 and o_window_valid pulses once in the cycle after the 16th save; o_window[7:0]=0x10, o_window[127:120]=0x1F.
REQ-031 SHALL pass this scenario: 17th save while full -> o_count stays 16, window unchanged, o_overflow=1 and stays 1 after a subsequent clear.
REQ-032 SHALL pass this scenario: clear pulse while full -> next cycle o_count=0, o_b1_empty=1, o_b1_full=0, o_window=0; the next save of 0xAA appears at o_window[7:0].
REQ-033 SHALL pass this scenario: save and clear in the same cycle after 5 saves -> o_count=0, o_overflow=0.
REQ-034 SHALL pass this scenario: n_rst pulled low after 7 saves, asynchronously between edges -> outputs reach reset values before the next edge; after release, 16 saves produce full normally.
REQ-035 SHALL pass this scenario: control-unit timing replay (save, wait 1 cycle, sample full) over 16 iterations -> full is sampled 0 for iterations 1..15 and 1 on iteration 16.
